// File: rtl/conv_layer_ctrl.sv
// Per-layer sequencer for the conv accelerator: accepts one descriptor, then
// steers the ifmap/weight load, the compute handshake and the ofmap drain.
module conv_layer_ctrl #(
  parameter int CNT_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] params_ifmap_cnt,
  input  logic [CNT_W-1:0] params_wt_cnt,
  input  logic [CNT_W-1:0] params_ofmap_cnt,
  input  logic             params_vld,
  output logic             params_rdy,
  input  logic             ifmap_src_vld,
  output logic             ifmap_src_rdy,
  output logic             ifmap_core_vld,
  input  logic             ifmap_core_rdy,
  input  logic             wt_src_vld,
  output logic             wt_src_rdy,
  output logic             wt_core_vld,
  input  logic             wt_core_rdy,
  input  logic             ofmap_core_vld,
  output logic             ofmap_core_rdy,
  output logic             ofmap_dst_vld,
  input  logic             ofmap_dst_rdy,
  output logic             core_start,
  input  logic             core_done,
  output logic             layer_done,
  output logic             busy,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] if_rem_q, if_rem_d;
  logic [CNT_W-1:0] wt_rem_q, wt_rem_d;
  logic [CNT_W-1:0] of_rem_q, of_rem_d;
  logic             params_rdy_q, params_rdy_d;
  logic             core_start_q, core_start_d;
  logic             layer_done_q, layer_done_d;
  logic             err_q, err_d;

  logic ifmap_en, wt_en, of_en;
  logic if_hs, wt_hs, of_hs;
  logic accept;

  // Enables come from registers only, so the gated paths stay purely combinational.
  assign ifmap_en = (state_q == S_LOAD)  && (if_rem_q != '0);
  assign wt_en    = (state_q == S_LOAD)  && (wt_rem_q != '0);
  assign of_en    = (state_q == S_DRAIN) && (of_rem_q != '0);

  assign ifmap_src_rdy  = ifmap_core_rdy & ifmap_en;
  assign ifmap_core_vld = ifmap_src_vld  & ifmap_en;
  assign wt_src_rdy     = wt_core_rdy    & wt_en;
  assign wt_core_vld    = wt_src_vld     & wt_en;
  assign ofmap_core_rdy = ofmap_dst_rdy  & of_en;
  assign ofmap_dst_vld  = ofmap_core_vld & of_en;

  assign if_hs  = ifmap_src_vld  & ifmap_core_rdy & ifmap_en;
  assign wt_hs  = wt_src_vld     & wt_core_rdy    & wt_en;
  assign of_hs  = ofmap_core_vld & ofmap_dst_rdy  & of_en;
  assign accept = (state_q == S_IDLE) & params_vld & params_rdy_q;

  assign params_rdy = params_rdy_q;
  assign core_start = core_start_q;
  assign layer_done = layer_done_q;
  assign busy       = (state_q != S_IDLE);
  assign err        = err_q;

  always_comb begin
    state_d      = state_q;
    if_rem_d     = if_hs ? (if_rem_q - ONE) : if_rem_q;
    wt_rem_d     = wt_hs ? (wt_rem_q - ONE) : wt_rem_q;
    of_rem_d     = of_hs ? (of_rem_q - ONE) : of_rem_q;
    params_rdy_d = 1'b0;
    core_start_d = 1'b0;
    layer_done_d = 1'b0;
    // core_done is only legal while the core is actually computing (or just finished).
    err_d        = err_q | (core_done & ((state_q == S_IDLE) ||
                                         (state_q == S_LOAD) ||
                                         (state_q == S_DRAIN)));
    case (state_q)
      S_IDLE: begin
        params_rdy_d = 1'b1;
        if (accept) begin
          if_rem_d     = params_ifmap_cnt;
          wt_rem_d     = params_wt_cnt;
          of_rem_d     = params_ofmap_cnt;
          err_d        = 1'b0;
          params_rdy_d = 1'b0;
          state_d      = S_LOAD;
        end
      end
      S_LOAD: begin
        if ((if_rem_q == '0) && (wt_rem_q == '0)) begin
          state_d      = S_COMPUTE;
          core_start_d = 1'b1;
        end
      end
      S_COMPUTE: begin
        // A done seen alongside the start pulse belongs to a stale compute.
        if (!core_start_q && core_done) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (of_rem_q == '0) begin
          state_d      = S_DONE;
          layer_done_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      if_rem_q     <= '0;
      wt_rem_q     <= '0;
      of_rem_q     <= '0;
      params_rdy_q <= 1'b0;
      core_start_q <= 1'b0;
      layer_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      if_rem_q     <= if_rem_d;
      wt_rem_q     <= wt_rem_d;
      of_rem_q     <= of_rem_d;
      params_rdy_q <= params_rdy_d;
      core_start_q <= core_start_d;
      layer_done_q <= layer_done_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Directed bench for conv_layer_ctrl: expected per-layer handshake totals are
// queued at descriptor time and checked when layer_done is observed.
module tb_conv_layer_ctrl;

  localparam int CNT_W = 18;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] params_ifmap_cnt, params_wt_cnt, params_ofmap_cnt;
  logic             params_vld, params_rdy;
  logic             ifmap_src_vld, ifmap_src_rdy, ifmap_core_vld, ifmap_core_rdy;
  logic             wt_src_vld, wt_src_rdy, wt_core_vld, wt_core_rdy;
  logic             ofmap_core_vld, ofmap_core_rdy, ofmap_dst_vld, ofmap_dst_rdy;
  logic             core_start, core_done, layer_done, busy, err;

  conv_layer_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .params_ifmap_cnt(params_ifmap_cnt), .params_wt_cnt(params_wt_cnt),
    .params_ofmap_cnt(params_ofmap_cnt),
    .params_vld(params_vld), .params_rdy(params_rdy),
    .ifmap_src_vld(ifmap_src_vld), .ifmap_src_rdy(ifmap_src_rdy),
    .ifmap_core_vld(ifmap_core_vld), .ifmap_core_rdy(ifmap_core_rdy),
    .wt_src_vld(wt_src_vld), .wt_src_rdy(wt_src_rdy),
    .wt_core_vld(wt_core_vld), .wt_core_rdy(wt_core_rdy),
    .ofmap_core_vld(ofmap_core_vld), .ofmap_core_rdy(ofmap_core_rdy),
    .ofmap_dst_vld(ofmap_dst_vld), .ofmap_dst_rdy(ofmap_dst_rdy),
    .core_start(core_start), .core_done(core_done),
    .layer_done(layer_done), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ifc;
    int wtc;
    int ofc;
  } exp_t;

  exp_t sb_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int hs_if, hs_wt, hs_of, cs_cnt;
  int m_if_rem, m_wt_rem, m_of_rem;
  bit rand_mode = 0;
  bit ok;

  logic s_accept, s_params_rdy, s_busy, s_err, s_core_start, s_layer_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sampled at negedge: invariants, handshake counting, scoreboard pop.
  task automatic monitor();
    exp_t e;
    cyc++;
    if (rst) begin
      m_if_rem = 0; m_wt_rem = 0; m_of_rem = 0;
      hs_if = 0; hs_wt = 0; hs_of = 0;
    end
    if (m_if_rem == 0) chk("if_gated_when_done", {30'd0, ifmap_core_vld, ifmap_src_rdy}, 0);
    if (m_wt_rem == 0) chk("wt_gated_when_done", {30'd0, wt_core_vld, wt_src_rdy}, 0);
    if (m_of_rem == 0) chk("of_gated_when_done", {30'd0, ofmap_dst_vld, ofmap_core_rdy}, 0);
    chk("gated_vld_implies_src", {29'd0, ifmap_core_vld & ~ifmap_src_vld,
        wt_core_vld & ~wt_src_vld, ofmap_dst_vld & ~ofmap_core_vld}, 0);
    chk("params_rdy_while_busy", {31'd0, params_rdy & busy}, 0);

    if (ifmap_src_vld & ifmap_src_rdy) begin hs_if++; m_if_rem--; end
    if (wt_src_vld & wt_src_rdy)       begin hs_wt++; m_wt_rem--; end
    if (ofmap_core_vld & ofmap_core_rdy) begin hs_of++; m_of_rem--; end
    if (core_start) cs_cnt++;

    s_accept     = params_vld & params_rdy & ~rst;
    s_params_rdy = params_rdy;
    s_busy       = busy;
    s_err        = err;
    s_core_start = core_start;
    s_layer_done = layer_done;

    if (s_accept) begin
      m_if_rem = int'(params_ifmap_cnt);
      m_wt_rem = int'(params_wt_cnt);
      m_of_rem = int'(params_ofmap_cnt);
      hs_if = 0; hs_wt = 0; hs_of = 0; cs_cnt = 0;
      acc_cyc = cyc;
    end
    if (layer_done) begin
      if (sb_q.size() == 0) begin
        chk("scoreboard_empty_at_layer_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("layer_ifmap_handshakes", hs_if, e.ifc);
        chk("layer_wt_handshakes", hs_wt, e.wtc);
        chk("layer_ofmap_handshakes", hs_of, e.ofc);
        chk("layer_core_start_pulses", cs_cnt, 1);
      end
    end
  endtask

  // Samples the current cycle, then returns just after the next posedge for driving.
  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      ifmap_src_vld  = ($urandom_range(0, 3) != 0);
      ifmap_core_rdy = ($urandom_range(0, 3) != 0);
      wt_src_vld     = ($urandom_range(0, 3) != 0);
      wt_core_rdy    = ($urandom_range(0, 3) != 0);
      ofmap_core_vld = ($urandom_range(0, 3) != 0);
      ofmap_dst_rdy  = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic streams(input logic v);
    ifmap_src_vld = v; ifmap_core_rdy = v;
    wt_src_vld = v;    wt_core_rdy = v;
    ofmap_core_vld = v; ofmap_dst_rdy = v;
  endtask

  task automatic send_params(input int ic, input int wc, input int oc);
    exp_t e;
    e.ifc = ic; e.wtc = wc; e.ofc = oc;
    sb_q.push_back(e);
    params_ifmap_cnt = CNT_W'(ic);
    params_wt_cnt    = CNT_W'(wc);
    params_ofmap_cnt = CNT_W'(oc);
    params_vld = 1'b1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      cycle();
      if (s_accept) ok = 1;
    end
    params_vld = 1'b0;
    if (!ok) chk("params_accept_timeout", 0, 1);
  endtask

  task automatic wait_start(input int budget);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      cycle();
      if (s_core_start) ok = 1;
    end
    if (!ok) chk("core_start_timeout", 0, 1);
  endtask

  task automatic wait_layer_done(input int budget);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      cycle();
      if (s_layer_done) ok = 1;
    end
    if (!ok) chk("layer_done_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    params_vld = 1'b0;
    params_ifmap_cnt = '0; params_wt_cnt = '0; params_ofmap_cnt = '0;
    core_done = 1'b0;
    streams(1'b1);
    hs_if = 0; hs_wt = 0; hs_of = 0; cs_cnt = 0;
    m_if_rem = 0; m_wt_rem = 0; m_of_rem = 0;

    // Reset state, with all stream inputs asserted so gating is exercised.
    cycle();
    cycle();
    chk("rst_params_rdy", s_params_rdy, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_err", s_err, 0);
    chk("rst_core_start_layer_done", {30'd0, s_core_start, s_layer_done}, 0);
    rst = 1'b0;

    // 1: basic layer {4,3,2}, streams always ready.
    send_params(4, 3, 2);
    wait_start(100);
    chk("t1_if_before_start", hs_if, 4);
    chk("t1_wt_before_start", hs_wt, 3);
    chk("t1_of_before_start", hs_of, 0);
    for (int i = 0; i < 4; i++) cycle();
    core_done = 1'b1;
    cycle();
    core_done = 1'b0;
    wait_layer_done(100);
    cycle();
    chk("t1_busy_after", s_busy, 0);
    chk("t1_err", s_err, 0);

    // 2: random stalls on all streams.
    rand_mode = 1;
    send_params(100, 57, 33);
    wait_start(3000);
    chk("t2_if_before_start", hs_if, 100);
    chk("t2_wt_before_start", hs_wt, 57);
    chk("t2_of_before_start", hs_of, 0);
    for (int i = 0; i < 3; i++) cycle();
    core_done = 1'b1;
    cycle();
    core_done = 1'b0;
    wait_layer_done(3000);
    rand_mode = 0;
    streams(1'b1);

    // 3: all-zero counts with core_done tied high.
    core_done = 1'b1;
    send_params(0, 0, 0);
    wait_layer_done(50);
    chk("t3_layer_done_latency", cyc - acc_cyc, 5);
    core_done = 1'b0;
    cycle();

    // 4: stray core_done during LOAD sets sticky err.
    send_params(3, 2, 1);
    core_done = 1'b1;
    cycle();
    core_done = 1'b0;
    chk("t4_err_cleared_on_accept", s_err, 0);
    cycle();
    chk("t4_err_set_in_load", s_err, 1);
    wait_start(100);
    cycle();
    core_done = 1'b1;
    cycle();
    core_done = 1'b0;
    wait_layer_done(100);
    chk("t4_err_sticky", s_err, 1);

    // 5: reset mid-LOAD after two ifmap words.
    send_params(4, 3, 2);
    cycle();
    chk("t5_err_cleared_by_accept", s_err, 0);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (hs_if >= 2) ok = 1;
      else cycle();
    end
    if (!ok) chk("t5_partial_timeout", 0, 1);
    chk("t5_partial_if", hs_if, 2);
    rst = 1'b1;
    #1;
    chk("t5_rst_ctrl", {27'd0, params_rdy, busy, core_start, layer_done, err}, 0);
    chk("t5_rst_gates", {26'd0, ifmap_src_rdy, ifmap_core_vld, wt_src_rdy, wt_core_vld,
        ofmap_core_rdy, ofmap_dst_vld}, 0);
    sb_q.delete();
    cycle();
    cycle();
    rst = 1'b0;
    send_params(4, 0, 0);
    wait_start(100);
    chk("t5_fresh_if", hs_if, 4);
    cycle();
    core_done = 1'b1;
    cycle();
    core_done = 1'b0;
    wait_layer_done(100);

    // 6: back-to-back layers, params_vld held high.
    begin
      exp_t e;
      e.ifc = 1; e.wtc = 1; e.ofc = 1;
      sb_q.push_back(e);
      sb_q.push_back(e);
    end
    params_ifmap_cnt = 18'd1; params_wt_cnt = 18'd1; params_ofmap_cnt = 18'd1;
    core_done = 1'b1;
    params_vld = 1'b1;
    wait_layer_done(100);
    cycle();
    chk("t6_rdy_low_after_done", s_params_rdy, 0);
    chk("t6_idle_after_done", s_busy, 0);
    cycle();
    chk("t6_rdy_rerise", s_params_rdy, 1);
    chk("t6_second_accept", s_accept, 1);
    cycle();
    chk("t6_busy_after_accept", s_busy, 1);
    chk("t6_rdy_low_busy", s_params_rdy, 0);
    wait_layer_done(100);
    params_vld = 1'b0;
    core_done = 1'b0;
    cycle();
    cycle();
    chk("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
